// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register with load-use hazard detection.
//               Captures the decoded control word and operands from the
//               decode stage and presents them to execute one cycle later.
//               Inserts a bubble (all fields and valid cleared) when EX
//               flushes on a taken branch/jump, or when the instruction in
//               EX is a load whose destination is read by the instruction
//               in ID. Two saturating counters record how many bubbles of
//               each kind were inserted.
// Ports       : clk, reset (sync, active-low)
//               flush        - squash the ID instruction (branch taken in EX)
//               id_*         - decode-stage control word, operands, fields
//               ex_*         - registered copies of id_*, plus ex_valid
//               hazard_stall - combinational; hold PC and IF/ID this cycle
//               stall_cnt    - saturating count of load-use bubbles
//               flush_cnt    - saturating count of flush bubbles
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
  parameter int PC_W    = 9,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               id_valid,
  input  logic               id_alusrc,
  input  logic               id_memtoreg,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic [1:0]         id_aluop,
  input  logic               id_branch,
  input  logic               id_jalrsel,
  input  logic [PC_W-1:0]    id_pc,
  input  logic [DATA_W-1:0]  id_rd1,
  input  logic [DATA_W-1:0]  id_rd2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [2:0]         id_funct3,
  input  logic [6:0]         id_funct7,
  output logic               ex_valid,
  output logic               ex_alusrc,
  output logic               ex_memtoreg,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic [1:0]         ex_aluop,
  output logic               ex_branch,
  output logic               ex_jalrsel,
  output logic [PC_W-1:0]    ex_pc,
  output logic [DATA_W-1:0]  ex_rd1,
  output logic [DATA_W-1:0]  ex_rd2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [RADDR_W-1:0] ex_rs1,
  output logic [RADDR_W-1:0] ex_rs2,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [2:0]         ex_funct3,
  output logic [6:0]         ex_funct7,
  output logic               hazard_stall,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic dest_match;
  logic bubble;

  // rs2 is compared even for instructions that do not read it; a spurious
  // one-cycle stall is harmless, a missed hazard is not.
  assign dest_match   = (ex_rd == id_rs1) | (ex_rd == id_rs2);

  // A flush kills the ID instruction anyway, so it masks the stall request.
  assign hazard_stall = ex_valid & ex_memread & (ex_rd != '0) & id_valid
                        & dest_match & ~flush;

  assign bubble       = flush | hazard_stall;

  // Pipeline register. A bubble clears every field so EX sees a clean NOP,
  // which also drops ex_memread and lets the stalled instruction through
  // on the following cycle.
  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      ex_valid    <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_aluop    <= '0;
      ex_branch   <= 1'b0;
      ex_jalrsel  <= 1'b0;
      ex_pc       <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
    end else begin
      // An invalid ID slot is captured verbatim; only ex_valid marks it.
      ex_valid    <= id_valid;
      ex_alusrc   <= id_alusrc;
      ex_memtoreg <= id_memtoreg;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_aluop    <= id_aluop;
      ex_branch   <= id_branch;
      ex_jalrsel  <= id_jalrsel;
      ex_pc       <= id_pc;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7   <= id_funct7;
    end
  end

  // Bubble counters, saturating at all-ones. hazard_stall is already
  // masked by flush, so at most one counter advances per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (hazard_stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
